// File: rtl/hilo_commit_unit.sv
// HI/LO commit stage behind MULT32: captures a product, commits it after LATENCY cycles,
// and provides MTHI/MTLO writes, the MFHI/MFLO read mux and a read interlock. Optional: HILO_ACC_EN.
module hilo_commit_unit #(
    parameter int LATENCY = 4,
    parameter int CNT_W   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        mul_acc_i,
    input  logic [31:0] mul_hi_i,
    input  logic [31:0] mul_lo_i,
    input  logic        mthi_i,
    input  logic        mtlo_i,
    input  logic [31:0] wdata_i,
    input  logic        rd_req_i,
    input  logic        rd_sel_i,
    output logic [31:0] rdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        stall_o
);

    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_BUSY  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      prod_q, prod_d;
    logic             acc_q, acc_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             done_q, done_d;

    logic             mt_any;
    logic             commit;
    logic [63:0]      commit_val;

    assign mt_any = mthi_i | mtlo_i;
    // A move-to in the final busy cycle still wins over the commit.
    assign commit = (state_q == ST_BUSY) && (cnt_q == '0) && !mt_any;

`ifdef HILO_ACC_EN
    assign commit_val = acc_q ? ({hi_q, lo_q} + prod_q) : prod_q;
`else
    logic unused_acc;
    assign unused_acc = acc_q;
    assign commit_val = prod_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = commit;
        case (state_q)
            ST_IDLE: begin
                if (mthi_i) hi_d = wdata_i;
                if (mtlo_i) lo_d = wdata_i;
                if (start_i) begin
                    prod_d  = {mul_hi_i, mul_lo_i};
                    acc_d   = mul_acc_i;
                    cnt_d   = CNT_INIT;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mt_any) begin
                    if (mthi_i) hi_d = wdata_i;
                    if (mtlo_i) lo_d = wdata_i;
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = commit_val;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            acc_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign busy_o  = (state_q == ST_BUSY);
    assign done_o  = done_q;
    assign stall_o = rd_req_i & busy_o;
    assign rdata_o = rd_sel_i ? hi_q : lo_q;

endmodule

// File: tb/tb_hilo_commit_unit.sv
// Scoreboard bench for hilo_commit_unit: a cycle-level reference model predicts outputs and commits.
module tb_hilo_commit_unit;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, mul_acc = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [31:0] mul_hi = '0, mul_lo = '0, wdata = '0;
    logic        rd_req = 1'b0, rd_sel = 1'b0;
    logic [31:0] rdata, hi, lo;
    logic        busy, done, stall;

    always #5 clk = ~clk;

    hilo_commit_unit #(.LATENCY(LAT), .CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mul_acc_i(mul_acc),
        .mul_hi_i(mul_hi), .mul_lo_i(mul_lo), .mthi_i(mthi), .mtlo_i(mtlo),
        .wdata_i(wdata), .rd_req_i(rd_req), .rd_sel_i(rd_sel),
        .rdata_o(rdata), .hi_o(hi), .lo_o(lo), .busy_o(busy), .done_o(done), .stall_o(stall)
    );

    typedef struct {
        logic        rst, start, acc, mthi, mtlo, rd_req, rd_sel;
        logic [31:0] a, b, wdata;
    } stim_t;

    typedef struct {
        logic        busy, done, stall;
        logic [31:0] hi, lo, rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] commit_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: architectural state plus the absolute edge at which a pending product lands.
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_pending = 1'b0, m_done = 1'b0, m_acc = 1'b0;
    logic [63:0] m_prod = '0;
    int          m_commit_edge = 0;
    int          edge_no = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv)
            $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
        else
            n_pass++;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{rst: 1'b0, start: 1'b0, acc: 1'b0, mthi: 1'b0, mtlo: 1'b0, rd_req: 1'b0,
              rd_sel: 1'b0, a: 32'd0, b: 32'd0, wdata: 32'd0};
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t        e;
        logic [63:0] p;
        logic [63:0] nv;
        @(negedge clk);
        p       = {32'd0, s.a} * {32'd0, s.b};
        rst     = s.rst;
        start   = s.start;
        mul_acc = s.acc;
        mul_hi  = p[63:32];
        mul_lo  = p[31:0];
        mthi    = s.mthi;
        mtlo    = s.mtlo;
        wdata   = s.wdata;
        rd_req  = s.rd_req;
        rd_sel  = s.rd_sel;
        e.busy  = m_pending;
        e.done  = m_done;
        e.stall = s.rd_req & m_pending;
        e.hi    = m_hi;
        e.lo    = m_lo;
        e.rdata = s.rd_sel ? m_hi : m_lo;
        exp_q.push_back(e);
        m_done = 1'b0;
        if (s.rst) begin
            m_hi = '0; m_lo = '0; m_pending = 1'b0; m_prod = '0; m_acc = 1'b0;
        end else if (m_pending) begin
            if (s.mthi || s.mtlo) begin
                if (s.mthi) m_hi = s.wdata;
                if (s.mtlo) m_lo = s.wdata;
                m_pending = 1'b0;
            end else if (edge_no == m_commit_edge) begin
                nv = m_prod;
`ifdef HILO_ACC_EN
                if (m_acc) nv = {m_hi, m_lo} + m_prod;
`endif
                {m_hi, m_lo} = nv;
                m_done       = 1'b1;
                m_pending    = 1'b0;
                commit_q.push_back(nv);
            end
        end else begin
            if (s.mthi) m_hi = s.wdata;
            if (s.mtlo) m_lo = s.wdata;
            if (s.start) begin
                m_pending     = 1'b1;
                m_prod        = p;
                m_acc         = s.acc;
                m_commit_edge = edge_no + LAT;
            end
        end
        edge_no++;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(idle_stim());
    endtask

    // Monitor: compares every cycle's outputs, and the committed pair whenever DONE is presented.
    initial begin
        exp_t        e;
        logic [63:0] c;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("busy",  {63'd0, busy},  {63'd0, e.busy});
                chk("done",  {63'd0, done},  {63'd0, e.done});
                chk("stall", {63'd0, stall}, {63'd0, e.stall});
                chk("hilo",  {hi, lo},       {e.hi, e.lo});
                chk("rdata", {32'd0, rdata}, {32'd0, e.rdata});
                $display("cyc t=%0t busy=%0b done=%0b stall=%0b hi=%08h lo=%08h rdata=%08h",
                         $time, busy, done, stall, hi, lo, rdata);
            end
            if (done === 1'b1) begin
                if (commit_q.size() == 0) begin
                    chk("done_unexpected", 64'd1, 64'd0);
                end else begin
                    c = commit_q.pop_front();
                    chk("commit", {hi, lo}, c);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout at t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        // Reset held with start and mthi active: everything must stay zero.
        s = idle_stim(); s.rst = 1'b1; s.start = 1'b1; s.mthi = 1'b1; s.wdata = 32'hdeadbeef;
        s.a = 32'd5; s.b = 32'd6;
        step(s); step(s);
        idle_n(2);
        // 7*7
        s = idle_stim(); s.start = 1'b1; s.a = 32'd7; s.b = 32'd7;
        step(s);
        idle_n(6);
        // max*max with a redundant START at E2
        s = idle_stim(); s.start = 1'b1; s.a = 32'hffffffff; s.b = 32'hffffffff;
        step(s);
        idle_n(1);
        s.a = 32'd3; s.b = 32'd3;
        step(s);
        idle_n(5);
        // MTLO cancels an in-flight multiply
        s = idle_stim(); s.start = 1'b1; s.a = 32'd1234; s.b = 32'd5678;
        step(s);
        idle_n(1);
        s = idle_stim(); s.mtlo = 1'b1; s.wdata = 32'h12345678;
        step(s);
        idle_n(5);
        // MFHI stall during busy
        s = idle_stim(); s.start = 1'b1; s.a = 32'h00010000; s.b = 32'h00030000; s.rd_req = 1'b1; s.rd_sel = 1'b1;
        step(s);
        s.start = 1'b0;
        for (int i = 0; i < 6; i++) step(s);
        // Accumulate case: HI/LO = 0/ffffffff plus product 1
        s = idle_stim(); s.mthi = 1'b1; s.mtlo = 1'b1; s.wdata = 32'd0; step(s);
        s = idle_stim(); s.mtlo = 1'b1; s.wdata = 32'hffffffff; step(s);
        s = idle_stim(); s.start = 1'b1; s.acc = 1'b1; s.a = 32'd1; s.b = 32'd1; step(s);
        idle_n(6);
        // Reset in the middle of a multiply
        s = idle_stim(); s.start = 1'b1; s.a = 32'd99; s.b = 32'd99; step(s);
        idle_n(1);
        s = idle_stim(); s.rst = 1'b1; step(s);
        idle_n(6);
        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            s = idle_stim();
            s.rst    = ($urandom_range(0, 199) == 0);
            s.start  = ($urandom_range(0, 3) == 0);
            s.acc    = $urandom_range(0, 1) == 1;
            s.a      = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
            s.b      = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
            s.mthi   = ($urandom_range(0, 15) == 0);
            s.mtlo   = ($urandom_range(0, 15) == 0);
            s.wdata  = $urandom;
            s.rd_req = ($urandom_range(0, 2) == 0);
            s.rd_sel = $urandom_range(0, 1) == 1;
            step(s);
        end
        idle_n(LAT + 3);
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #4;
        chk("scoreboard_drained", {32'(exp_q.size()), 32'(commit_q.size())}, 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
